mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single external memory bus between the CPU core and a second bus master (DMA / video fetch), one access at a time. Each requester presents a level request with address, write-enable and write data. The arbiter grants one requester, runs a fixed-length memory cycle on the shared bus with WAIT_STATES stretch cycles, and returns read data with a one-cycle acknowledge. It sits between the CPU's memory strobes (n_oe_mem/n_we_mem domain) and the physical RAM/ROM.

## Interface
- WAIT_STATES, 1, extra ACCESS cycles per memory cycle; legal range 0..15
- ADDR_W, 16, address width
- DATA_W, 8, data width

- clk  in  1  single clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, registered
- cpu_ack  out  1  one-cycle completion pulse for CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as cpu_* for the second master
- mem_addr  out  ADDR_W  shared bus address
- mem_wdata  out  DATA_W  shared bus write data
- mem_rdata  in  DATA_W  shared bus read data
- n_mem_oe  out  1  memory output enable, active low
- n_mem_we  out  1  memory write enable, active low
- gnt_dma  out  1  current/last owner: 0 = CPU, 1 = DMA
- busy  out  1  high in ACCESS and RELEASE

## Operation
- States: IDLE, ACCESS, RELEASE. 4-bit wait counter cnt.
- IDLE: if no req, stay. If exactly one req, grant it. If both, pick winner per Configuration. On the grant edge: latch winner's addr/we/wdata into internal registers, set gnt_dma, cnt = WAIT_STATES, go ACCESS.
- ACCESS: mem_addr/mem_wdata from latched registers. Read: n_mem_oe = 0. Write: n_mem_we = 0. If cnt != 0, decrement and stay. If cnt == 0, go RELEASE; for a read, capture mem_rdata into the granted port's rdata register on that edge.
- RELEASE: n_mem_oe = n_mem_we = 1; mem_addr/mem_wdata still held (hold time). Granted port's ack = 1. Next state is always IDLE.
- Requester contract: hold req and its address/data stable until ack is sampled high. Deassert req on that same edge unless a new access follows immediately. req high in IDLE always means a new request.
- Writes never modify either rdata register. The non-granted port's rdata and ack are untouched.
- A request arriving during another's cycle waits. The arbiter never preempts.
- mem_addr/mem_wdata in IDLE hold the last latched values and are don't-care to memory since the strobes are high.
- Reset (any time, including mid-ACCESS): immediately state = IDLE, n_mem_oe = n_mem_we = 1, cpu_ack = dma_ack = 0, busy = 0, cpu_rdata = dma_rdata = 0, mem_addr = 0, mem_wdata = 0, cnt = 0, gnt_dma = 1 (so CPU wins the first contended round-robin grant). An interrupted access is dropped, not replayed.

## Timing
- Request sampled high in IDLE at edge k:
  - ACCESS occupies cycles k+1 .. k+1+WAIT_STATES.
  - RELEASE with ack = 1 is cycle k+2+WAIT_STATES.
  - IDLE is at k+3+WAIT_STATES.
- Latency req-to-ack = WAIT_STATES+2 cycles. Bus occupancy per access = WAIT_STATES+3 cycles including the IDLE arbitration cycle.
- Strobes, ack, busy and rdata are registered/state-decoded only. No combinational path from any req to any output.
- WAIT_STATES = 0: exactly one ACCESS cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted last, i.e. the opposite of gnt_dma. Two continuously requesting masters alternate CPU, DMA, CPU, ...
- Undefined: fixed priority. On contention the CPU always wins; DMA is granted only in an IDLE cycle with cpu_req low.
- Uncontended behaviour is identical in both builds.

## Test plan
- Reset mid-write: assert rst during ACCESS with n_mem_we = 0 -> n_mem_we = 1 immediately (asynchronously), state IDLE, acks 0, rdata 0.
- CPU read, WAIT_STATES = 1, cpu_addr = 0x1234, mem_rdata = 0xA5 -> n_mem_oe low for 2 cycles; cpu_ack pulses at req-edge+3; cpu_rdata = 0xA5; dma_rdata unchanged.
- DMA write, WAIT_STATES = 0, dma_addr = 0x8000, dma_wdata = 0x3C -> n_mem_we low exactly 1 cycle with mem_addr = 0x8000 and mem_wdata = 0x3C; both held in RELEASE; dma_ack at edge+2; cpu_rdata and dma_rdata unchanged.
- Both requesting continuously for 4 accesses:
  - with MEM_ARB_ROUND_ROBIN_EN -> grants CPU, DMA, CPU, DMA;
  - without it -> grants CPU ×4 and dma_ack never asserts.
- DMA request raised during a CPU ACCESS -> CPU completes unpreempted; DMA granted in the following IDLE; dma_ack exactly WAIT_STATES+3 cycles after the CPU's RELEASE cycle.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / DMA) arbiter for a single external memory bus with a fixed-length, wait-stated access cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise the CPU has fixed priority.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              n_mem_oe,
    output logic              n_mem_we,
    output logic              gnt_dma,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                gnt_dma_q;
    logic                n_oe_q;
    logic                n_we_q;
    logic                cpu_ack_q;
    logic                dma_ack_q;
    logic                busy_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   dma_rdata_q;

    logic                win_dma_d;
    logic                win_we_d;
    logic [ADDR_W-1:0]   win_addr_d;
    logic [DATA_W-1:0]   win_wdata_d;

    // Pick the winning requester and mux its access fields for the grant edge
    always_comb begin
        win_dma_d = 1'b0;
        if (cpu_req && dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_dma_d = ~gnt_dma_q;
`else
            win_dma_d = 1'b0;
`endif
        end else if (dma_req) begin
            win_dma_d = 1'b1;
        end else begin
            win_dma_d = 1'b0;
        end

        win_we_d    = cpu_we;
        win_addr_d  = cpu_addr;
        win_wdata_d = cpu_wdata;
        if (win_dma_d) begin
            win_we_d    = dma_we;
            win_addr_d  = dma_addr;
            win_wdata_d = dma_wdata;
        end else begin
            win_we_d    = cpu_we;
            win_addr_d  = cpu_addr;
            win_wdata_d = cpu_wdata;
        end
    end

    // Access FSM; strobes, acks, busy and read data are all registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            gnt_dma_q   <= 1'b1;
            n_oe_q      <= 1'b1;
            n_we_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    if (cpu_req || dma_req) begin
                        gnt_dma_q <= win_dma_d;
                        addr_q    <= win_addr_d;
                        wdata_q   <= win_wdata_d;
                        we_q      <= win_we_d;
                        cnt_q     <= WAIT_INIT;
                        n_oe_q    <= win_we_d;
                        n_we_q    <= ~win_we_d;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        n_oe_q  <= 1'b1;
                        n_we_q  <= 1'b1;
                        state_q <= ST_RELEASE;
                        if (gnt_dma_q) begin
                            dma_ack_q <= 1'b1;
                            if (!we_q) begin
                                dma_rdata_q <= mem_rdata;
                            end
                        end else begin
                            cpu_ack_q <= 1'b1;
                            if (!we_q) begin
                                cpu_rdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                ST_RELEASE: begin
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    n_oe_q    <= 1'b1;
                    n_we_q    <= 1'b1;
                    cpu_ack_q <= 1'b0;
                    dma_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign n_mem_oe  = n_oe_q;
    assign n_mem_we  = n_we_q;
    assign gnt_dma   = gnt_dma_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scoreboard of expected accesses popped on each ack.
// A second instance with WAIT_STATES = 0 covers the zero-wait case.
module tb_mem_bus_arbiter;

    localparam int WS = 1;

    logic        clk;
    logic        rst;

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        n_mem_oe, n_mem_we, gnt_dma, busy;

    logic        w0_cpu_req, w0_cpu_we, w0_dma_req, w0_dma_we;
    logic [15:0] w0_cpu_addr, w0_dma_addr;
    logic [7:0]  w0_cpu_wdata, w0_dma_wdata;
    logic [7:0]  w0_cpu_rdata, w0_dma_rdata;
    logic        w0_cpu_ack, w0_dma_ack;
    logic [15:0] w0_mem_addr;
    logic [7:0]  w0_mem_wdata, w0_mem_rdata;
    logic        w0_n_mem_oe, w0_n_mem_we, w0_gnt_dma, w0_busy;

    typedef struct packed {
        logic        dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } sb_item_t;

    sb_item_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cpu_ack_cyc = 0;
    int dma_ack_cyc = 0;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_dma_rd = 8'h00;

    // Memory contents seen on reads: a fixed function of the address
    function automatic logic [7:0] rd_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h83;
    endfunction

    assign mem_rdata    = n_mem_oe    ? 8'h00 : rd_model(mem_addr);
    assign w0_mem_rdata = w0_n_mem_oe ? 8'h00 : rd_model(w0_mem_addr);

    mem_bus_arbiter #(.WAIT_STATES(WS), .ADDR_W(16), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .n_mem_oe(n_mem_oe), .n_mem_we(n_mem_we), .gnt_dma(gnt_dma), .busy(busy)
    );

    mem_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16), .DATA_W(8)) u_dut_ws0 (
        .clk(clk), .rst(rst),
        .cpu_req(w0_cpu_req), .cpu_we(w0_cpu_we), .cpu_addr(w0_cpu_addr), .cpu_wdata(w0_cpu_wdata),
        .cpu_rdata(w0_cpu_rdata), .cpu_ack(w0_cpu_ack),
        .dma_req(w0_dma_req), .dma_we(w0_dma_we), .dma_addr(w0_dma_addr), .dma_wdata(w0_dma_wdata),
        .dma_rdata(w0_dma_rdata), .dma_ack(w0_dma_ack),
        .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata), .mem_rdata(w0_mem_rdata),
        .n_mem_oe(w0_n_mem_oe), .n_mem_we(w0_n_mem_we), .gnt_dma(w0_gnt_dma), .busy(w0_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor for the main instance: every ack retires the oldest expected access
    initial begin
        int oe_cnt, we_cnt;
        bit prev_ack;
        sb_item_t e;
        oe_cnt = 0;
        we_cnt = 0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                oe_cnt = 0;
                we_cnt = 0;
                prev_ack = 1'b0;
            end else begin
                if (!n_mem_oe) oe_cnt++;
                if (!n_mem_we) we_cnt++;
                if (cpu_ack || dma_ack) begin
                    check_eq("ack_single_cycle", int'(prev_ack), 0);
                    check_eq("ack_onehot", int'(cpu_ack && dma_ack), 0);
                    if (cpu_ack) cpu_ack_cyc = cyc;
                    if (dma_ack) dma_ack_cyc = cyc;
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected_ack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("ack_port", int'(dma_ack), int'(e.dma));
                        check_eq("gnt_dma", int'(gnt_dma), int'(e.dma));
                        check_eq("busy_release", int'(busy), 1);
                        check_eq("strobes_release", int'({n_mem_oe, n_mem_we}), 3);
                        check_eq("addr_hold", int'(mem_addr), int'(e.addr));
                        if (e.we) check_eq("wdata_hold", int'(mem_wdata), int'(e.wdata));
                        check_eq("oe_cycles", oe_cnt, e.we ? 0 : WS + 1);
                        check_eq("we_cycles", we_cnt, e.we ? WS + 1 : 0);
                        if (!e.we) begin
                            if (e.dma) exp_dma_rd = rd_model(e.addr);
                            else       exp_cpu_rd = rd_model(e.addr);
                        end
                        check_eq("cpu_rdata", int'(cpu_rdata), int'(exp_cpu_rd));
                        check_eq("dma_rdata", int'(dma_rdata), int'(exp_dma_rd));
                    end
                    oe_cnt = 0;
                    we_cnt = 0;
                end
                prev_ack = cpu_ack || dma_ack;
            end
        end
    end

    task automatic access(input bit is_dma, input bit we, input logic [15:0] addr,
                          input logic [7:0] wdata, output int lat);
        sb_item_t e;
        bit acked;
        e.dma = is_dma;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        @(negedge clk);
        sb.push_back(e);
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0;
        acked = 1'b0;
        while (!acked && lat < 64) begin
            @(negedge clk);
            lat++;
            acked = is_dma ? dma_ack : cpu_ack;
        end
        if (!acked) check_eq("ack_timeout", 0, 1);
        if (is_dma) dma_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    task automatic w0_access(input bit is_dma, input bit we, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] exp_cpu,
                             input logic [7:0] exp_dma);
        int lat, low;
        bit acked;
        @(negedge clk);
        if (is_dma) begin
            w0_dma_req = 1'b1; w0_dma_we = we; w0_dma_addr = addr; w0_dma_wdata = wdata;
        end else begin
            w0_cpu_req = 1'b1; w0_cpu_we = we; w0_cpu_addr = addr; w0_cpu_wdata = wdata;
        end
        lat = 0;
        low = 0;
        acked = 1'b0;
        while (!acked && lat < 32) begin
            @(negedge clk);
            lat++;
            if (!w0_n_mem_oe || !w0_n_mem_we) begin
                low++;
                check_eq("w0_strobe_kind", int'({w0_n_mem_oe, w0_n_mem_we}), we ? 2 : 1);
                check_eq("w0_access_addr", int'(w0_mem_addr), int'(addr));
            end
            acked = is_dma ? w0_dma_ack : w0_cpu_ack;
        end
        check_eq("w0_latency", lat, 2);
        check_eq("w0_strobe_cycles", low, 1);
        check_eq("w0_other_ack", int'(is_dma ? w0_cpu_ack : w0_dma_ack), 0);
        check_eq("w0_addr_hold", int'(w0_mem_addr), int'(addr));
        if (we) check_eq("w0_wdata_hold", int'(w0_mem_wdata), int'(wdata));
        check_eq("w0_gnt_dma", int'(w0_gnt_dma), int'(is_dma));
        check_eq("w0_cpu_rdata", int'(w0_cpu_rdata), int'(exp_cpu));
        check_eq("w0_dma_rdata", int'(w0_dma_rdata), int'(exp_dma));
        w0_cpu_req = 1'b0;
        w0_dma_req = 1'b0;
    endtask

    task automatic check_rst_outputs(input string tag);
        check_eq({tag, "_n_oe"}, int'(n_mem_oe), 1);
        check_eq({tag, "_n_we"}, int'(n_mem_we), 1);
        check_eq({tag, "_acks"}, int'({cpu_ack, dma_ack}), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_rdata"}, int'({cpu_rdata, dma_rdata}), 0);
        check_eq({tag, "_mem_addr"}, int'(mem_addr), 0);
        check_eq({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        check_eq({tag, "_gnt_dma"}, int'(gnt_dma), 1);
    endtask

    initial begin
        int lat, lat_c, lat_d, acks, n;
        bit rr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
        w0_cpu_req = 1'b0; w0_cpu_we = 1'b0; w0_cpu_addr = 16'h0000; w0_cpu_wdata = 8'h00;
        w0_dma_req = 1'b0; w0_dma_we = 1'b0; w0_dma_addr = 16'h0000; w0_dma_wdata = 8'h00;
        repeat (2) @(negedge clk);
        check_rst_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", int'(busy), 0);

        access(1'b0, 1'b0, 16'h1234, 8'h00, lat);
        check_eq("cpu_read_latency", lat, WS + 2);
        check_eq("cpu_read_A5", int'(cpu_rdata), 8'hA5);

        access(1'b1, 1'b0, 16'h00F0, 8'h00, lat);
        check_eq("dma_read_latency", lat, WS + 2);

        access(1'b0, 1'b1, 16'h2000, 8'h11, lat);
        check_eq("cpu_write_latency", lat, WS + 2);

        fork
            access(1'b0, 1'b0, 16'h1234, 8'h00, lat_c);
            begin
                repeat (2) @(negedge clk);
                access(1'b1, 1'b1, 16'h4444, 8'h5E, lat_d);
            end
        join
        check_eq("no_preempt_gap", dma_ack_cyc - cpu_ack_cyc, WS + 3);

        // Both masters request continuously for four accesses
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sb_item_t e;
            e.dma = rr && (i % 2 == 1);
            e.we = 1'b0;
            e.addr = e.dma ? 16'h9ABC : 16'h0456;
            e.wdata = 8'h00;
            sb.push_back(e);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0456;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h9ABC;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (cpu_ack || dma_ack) acks++;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check_eq("contention_acks", acks, 4);
        check_eq("contention_sb_drained", sb.size(), 0);

        w0_access(1'b1, 1'b1, 16'h8000, 8'h3C, 8'h00, 8'h00);
        @(negedge clk);
        check_eq("w0_idle_busy", int'(w0_busy), 0);
        w0_access(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 8'h00);

        // Reset in the middle of a write access
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h77;
        @(negedge clk);
        check_eq("pre_reset_n_we", int'(n_mem_we), 0);
        #2 rst = 1'b1;
        #1;
        check_rst_outputs("mid_reset");
        cpu_req = 1'b0;
        exp_cpu_rd = 8'h00;
        exp_dma_rd = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 1'b0, 16'h0456, 8'h00, lat);
        check_eq("post_reset_latency", lat, WS + 2);
        check_eq("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
